spi_slave_buffer: RTL and testbench

// Host-side data stage sitting directly downstream of the SPI slave clock-domain synchronizer, entirely in the clk domain.
// - Feeds TX words to the sclk-domain shift engine via a preloaded txData register backed by a TX FIFO.
// - Captures received words into an RX FIFO.
// - Counts words per frame and flags TX underrun / RX overrun for the host.

---
 rtl/spi_slave_buffer.sv | 133 +++++++++++++
 tb/tb_spi_slave_buffer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_buffer.sv
// Host-side data stage behind the SPI slave synchronizer: TX preload register with its FIFO,
// RX capture FIFO, per-frame word counter and sticky underrun/overrun flags, all in the clk domain.
//
// state  | meaning
// IDLE   | no frame in progress; waiting for spiStart
// ACTIVE | frame in progress; spiEnd closes it, spiStart restarts it
module spi_slave_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD = '0,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spiBusy,
  input  logic                  spiStart,
  input  logic                  spiEnd,
  input  logic                  spiTxLoad,
  input  logic                  spiRxRdy,
  input  logic [DATA_WIDTH-1:0] rxWord,
  output logic [DATA_WIDTH-1:0] txData,
  input  logic                  txWrEn,
  input  logic [DATA_WIDTH-1:0] txWrData,
  output logic                  txFull,
  output logic [LW-1:0]         txLevel,
  input  logic                  rxRdEn,
  output logic [DATA_WIDTH-1:0] rxRdData,
  output logic                  rxEmpty,
  output logic [LW-1:0]         rxLevel,
  output logic                  frameDone,
  output logic [15:0]           frameWords,
  output logic                  txUnderrun,
  output logic                  rxOverrun,
  input  logic                  clrFlags
);

  localparam int AW = LW - 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] ONE_L = LW'(1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} stateType;

  stateType state, stateNext;

  logic [DATA_WIDTH-1:0] txMem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rxMem [FIFO_DEPTH];
  logic [LW-1:0] txWrPtr, txRdPtr, rxWrPtr, rxRdPtr;
  logic txEmpty, txPush, txPop, txValid;
  logic rxFull, rxPush, rxPop;
  logic unusedBusy;

  // spiBusy is status only; nothing in this stage depends on it
  assign unusedBusy = spiBusy;

  assign txLevel = txWrPtr - txRdPtr;
  assign txFull  = (txLevel == DEPTH_L);
  assign txEmpty = (txLevel == '0);
  assign txPop   = !txEmpty && (spiTxLoad || !txValid);
  assign txPush  = txWrEn && (!txFull || txPop);

  assign rxLevel  = rxWrPtr - rxRdPtr;
  assign rxFull   = (rxLevel == DEPTH_L);
  assign rxEmpty  = (rxLevel == '0);
  assign rxPop    = rxRdEn && !rxEmpty;
  assign rxPush   = spiRxRdy && (!rxFull || rxPop);
  assign rxRdData = rxMem[rxRdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (txPush) txMem[txWrPtr[AW-1:0]] <= txWrData;
    if (rxPush) rxMem[rxWrPtr[AW-1:0]] <= rxWord;
  end

  // txData only moves on a consume tick or while refilling an empty preload slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txWrPtr    <= '0;
      txRdPtr    <= '0;
      txData     <= FILL_WORD;
      txValid    <= 1'b0;
      txUnderrun <= 1'b0;
    end else begin
      if (txPush) txWrPtr <= txWrPtr + ONE_L;
      if (txPop) begin
        txRdPtr <= txRdPtr + ONE_L;
        txData  <= txMem[txRdPtr[AW-1:0]];
        txValid <= 1'b1;
      end else if (spiTxLoad) begin
        txData  <= FILL_WORD;
        txValid <= 1'b0;
      end
      txUnderrun <= (spiTxLoad && !txValid) || (txUnderrun && !clrFlags);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxWrPtr   <= '0;
      rxRdPtr   <= '0;
      rxOverrun <= 1'b0;
    end else begin
      if (rxPush) rxWrPtr <= rxWrPtr + ONE_L;
      if (rxPop) rxRdPtr <= rxRdPtr + ONE_L;
      rxOverrun <= (spiRxRdy && rxFull && !rxRdEn) || (rxOverrun && !clrFlags);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (spiStart) stateNext = ACTIVE;
      ACTIVE:  if (spiEnd) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // dropped words still count: frameWords reflects what the master clocked out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frameWords <= '0;
      frameDone  <= 1'b0;
    end else begin
      frameDone <= spiEnd;
      if (spiStart) frameWords <= spiRxRdy ? 16'd1 : 16'd0;
      else if (spiRxRdy && frameWords != 16'hFFFF) frameWords <= frameWords + 16'd1;
    end
  end

endmodule

// File: tb/tb_spi_slave_buffer.sv
// Self-checking bench for spi_slave_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based model of the FIFOs, preload slot, flags and frame counter.
module tb_spi_slave_buffer;

  localparam logic [7:0] FILL = 8'h00;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spiBusy = 0, spiStart = 0, spiEnd = 0, spiTxLoad = 0, spiRxRdy = 0;
  logic [7:0] rxWord = '0, txData, txWrData = '0, rxRdData;
  logic txWrEn = 0, txFull, rxRdEn = 0, rxEmpty, frameDone, txUnderrun, rxOverrun, clrFlags = 0;
  logic [4:0] txLevel, rxLevel;
  logic [15:0] frameWords;

  int checks = 0;
  int failures = 0;

  logic [7:0] txQ[$];
  logic [7:0] rxQ[$];
  logic [7:0] mTxData = FILL;
  bit mTxValid = 0, mUnder = 0, mOver = 0, mDone = 0;
  int mWords = 0;

  spi_slave_buffer dut (
    .clk(clk), .reset(reset), .spiBusy(spiBusy), .spiStart(spiStart), .spiEnd(spiEnd),
    .spiTxLoad(spiTxLoad), .spiRxRdy(spiRxRdy), .rxWord(rxWord), .txData(txData),
    .txWrEn(txWrEn), .txWrData(txWrData), .txFull(txFull), .txLevel(txLevel),
    .rxRdEn(rxRdEn), .rxRdData(rxRdData), .rxEmpty(rxEmpty), .rxLevel(rxLevel),
    .frameDone(frameDone), .frameWords(frameWords), .txUnderrun(txUnderrun),
    .rxOverrun(rxOverrun), .clrFlags(clrFlags)
  );

  always #5 clk = ~clk;

  task automatic modelClear();
    txQ.delete();
    rxQ.delete();
    mTxData = FILL;
    mTxValid = 0;
    mUnder = 0;
    mOver = 0;
    mDone = 0;
    mWords = 0;
  endtask

  // advance the model by one clock using the present inputs, then clock the DUT
  task automatic tick();
    int txN, rxN;
    bit tPop, tPush, rPop, rPush, uSet, oSet;
    txN = txQ.size();
    rxN = rxQ.size();
    tPop = (txN > 0) && (spiTxLoad || !mTxValid);
    tPush = txWrEn && (txN < 16 || tPop);
    rPop = rxRdEn && (rxN > 0);
    rPush = spiRxRdy && (rxN < 16 || rPop);
    uSet = spiTxLoad && !mTxValid;
    oSet = spiRxRdy && (rxN == 16) && !rxRdEn;
    if (tPop) begin
      mTxData = txQ.pop_front();
      mTxValid = 1;
    end else if (spiTxLoad) begin
      mTxData = FILL;
      mTxValid = 0;
    end
    if (tPush) txQ.push_back(txWrData);
    if (rPop) void'(rxQ.pop_front());
    if (rPush) rxQ.push_back(rxWord);
    mUnder = uSet || (mUnder && !clrFlags);
    mOver = oSet || (mOver && !clrFlags);
    if (spiStart) mWords = spiRxRdy ? 1 : 0;
    else if (spiRxRdy && mWords < 65535) mWords++;
    mDone = spiEnd;
    @(posedge clk);
    #1;
    spiStart = 0; spiEnd = 0; spiTxLoad = 0; spiRxRdy = 0;
    txWrEn = 0; rxRdEn = 0; clrFlags = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (txData !== FILL || txLevel !== 5'd0 || txFull !== 1'b0) begin
      failures++;
      $display("FAIL reset_tx txData=%h txLevel=%0d txFull=%b exp %h/0/0", txData, txLevel, txFull, FILL);
    end
    checks++;
    if (rxEmpty !== 1'b1 || rxLevel !== 5'd0) begin
      failures++;
      $display("FAIL reset_rx rxEmpty=%b rxLevel=%0d exp 1/0", rxEmpty, rxLevel);
    end
    checks++;
    if (frameDone !== 1'b0 || frameWords !== 16'd0 || txUnderrun !== 1'b0 || rxOverrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_status done=%b words=%0d und=%b ovr=%b exp all 0", frameDone, frameWords, txUnderrun, rxOverrun);
    end
    reset = 0;
    modelClear();
    tick();
  endtask

  task automatic test_tx_preload();
    txWrEn = 1; txWrData = 8'hA5; tick();
    txWrEn = 1; txWrData = 8'h5A; tick();
    checks++;
    if (txData !== 8'hA5 || txLevel !== 5'd1) begin
      failures++;
      $display("FAIL preload txData=%h txLevel=%0d exp a5/1", txData, txLevel);
    end
    spiStart = 1; spiTxLoad = 1; tick();
    checks++;
    if (txData !== 8'h5A || txUnderrun !== 1'b0) begin
      failures++;
      $display("FAIL first_load txData=%h und=%b exp 5a/0", txData, txUnderrun);
    end
    spiTxLoad = 1; tick();
    checks++;
    if (txData !== FILL || txUnderrun !== 1'b0) begin
      failures++;
      $display("FAIL drain_load txData=%h und=%b exp %h/0", txData, txUnderrun, FILL);
    end
    spiTxLoad = 1; tick();
    checks++;
    if (txData !== FILL || txUnderrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun txData=%h und=%b exp %h/1", txData, txUnderrun, FILL);
    end
    clrFlags = 1; tick();
    checks++;
    if (txUnderrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_clear und=%b exp 0", txUnderrun);
    end
    clrFlags = 1; spiTxLoad = 1; tick();
    checks++;
    if (txUnderrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun_set_prio und=%b exp 1", txUnderrun);
    end
    clrFlags = 1; spiEnd = 1; tick();
    checks++;
    if (frameDone !== 1'b1 || txUnderrun !== 1'b0) begin
      failures++;
      $display("FAIL preload_end done=%b und=%b exp 1/0", frameDone, txUnderrun);
    end
  endtask

  task automatic test_tx_full();
    for (int i = 0; i < 18; i++) begin
      txWrEn = 1; txWrData = 8'h30 + 8'(i); tick();
    end
    checks++;
    if (txLevel !== 5'd16 || txFull !== 1'b1 || txData !== 8'h30) begin
      failures++;
      $display("FAIL tx_full level=%0d full=%b txData=%h exp 16/1/30", txLevel, txFull, txData);
    end
    spiTxLoad = 1; txWrEn = 1; txWrData = 8'h99; tick();
    checks++;
    if (txLevel !== 5'd16 || txData !== 8'h31) begin
      failures++;
      $display("FAIL tx_full_pushpop level=%0d txData=%h exp 16/31", txLevel, txData);
    end
    for (int i = 0; i < 16; i++) begin
      spiTxLoad = 1; tick();
    end
    checks++;
    if (txData !== 8'h99 || txLevel !== 5'd0 || txUnderrun !== 1'b0) begin
      failures++;
      $display("FAIL tx_drain txData=%h level=%0d und=%b exp 99/0/0", txData, txLevel, txUnderrun);
    end
    spiTxLoad = 1; tick();
    clrFlags = 1; tick();
  endtask

  task automatic test_rx_overrun();
    spiStart = 1; spiTxLoad = 1; tick();
    clrFlags = 1; tick();
    for (int i = 0; i < 16; i++) begin
      spiRxRdy = 1; rxWord = 8'(i); tick();
    end
    checks++;
    if (rxLevel !== 5'd16 || rxOverrun !== 1'b0 || frameWords !== 16'd16) begin
      failures++;
      $display("FAIL rx_fill level=%0d ovr=%b words=%0d exp 16/0/16", rxLevel, rxOverrun, frameWords);
    end
    spiRxRdy = 1; rxWord = 8'h10; tick();
    checks++;
    if (rxLevel !== 5'd16 || rxOverrun !== 1'b1 || frameWords !== 16'd17) begin
      failures++;
      $display("FAIL rx_overrun level=%0d ovr=%b words=%0d exp 16/1/17", rxLevel, rxOverrun, frameWords);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rxRdData !== 8'(i) || rxEmpty !== 1'b0) begin
        failures++;
        $display("FAIL rx_order idx=%0d got=%h empty=%b exp %h/0", i, rxRdData, rxEmpty, 8'(i));
      end
      rxRdEn = 1; tick();
    end
    checks++;
    if (rxEmpty !== 1'b1 || rxLevel !== 5'd0) begin
      failures++;
      $display("FAIL rx_drained empty=%b level=%0d exp 1/0", rxEmpty, rxLevel);
    end
    clrFlags = 1; spiEnd = 1; tick();
  endtask

  task automatic test_frame();
    spiStart = 1; spiTxLoad = 1; tick();
    repeat (3) begin
      spiRxRdy = 1; rxWord = 8'($urandom); tick();
    end
    spiEnd = 1; tick();
    checks++;
    if (frameDone !== 1'b1 || frameWords !== 16'd3) begin
      failures++;
      $display("FAIL frame_done done=%b words=%0d exp 1/3", frameDone, frameWords);
    end
    tick();
    checks++;
    if (frameDone !== 1'b0 || frameWords !== 16'd3) begin
      failures++;
      $display("FAIL frame_hold done=%b words=%0d exp 0/3", frameDone, frameWords);
    end
    spiStart = 1; spiTxLoad = 1; tick();
    checks++;
    if (frameWords !== 16'd0) begin
      failures++;
      $display("FAIL frame_restart words=%0d exp 0", frameWords);
    end
    spiRxRdy = 1; tick();
    spiRxRdy = 1; tick();
    spiStart = 1; spiTxLoad = 1; spiRxRdy = 1; tick();
    checks++;
    if (frameWords !== 16'd1) begin
      failures++;
      $display("FAIL frame_missed_end words=%0d exp 1", frameWords);
    end
    spiEnd = 1; tick();
    tick();
    spiEnd = 1; tick();
    checks++;
    if (frameDone !== 1'b1) begin
      failures++;
      $display("FAIL frame_abort done=%b exp 1", frameDone);
    end
    repeat (6) begin
      rxRdEn = 1; tick();
    end
    clrFlags = 1; tick();
  endtask

  task automatic test_full_rx_rdwr();
    logic [7:0] w;
    for (int i = 0; i < 16; i++) begin
      spiRxRdy = 1; rxWord = 8'($urandom); tick();
    end
    w = 8'($urandom);
    spiRxRdy = 1; rxRdEn = 1; rxWord = w; tick();
    checks++;
    if (rxLevel !== 5'd16 || rxOverrun !== 1'b0) begin
      failures++;
      $display("FAIL rx_full_rdwr level=%0d ovr=%b exp 16/0", rxLevel, rxOverrun);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rxRdData !== rxQ[0]) begin
        failures++;
        $display("FAIL rx_full_order idx=%0d got=%h exp %h", i, rxRdData, rxQ[0]);
      end
      if (i == 15) begin
        checks++;
        if (rxRdData !== w) begin
          failures++;
          $display("FAIL rx_full_tail got=%h exp %h", rxRdData, w);
        end
      end
      rxRdEn = 1; tick();
    end
  endtask

  task automatic test_reset_midframe();
    spiStart = 1; spiTxLoad = 1; tick();
    for (int i = 0; i < 10; i++) begin
      txWrEn = 1; txWrData = 8'($urandom);
      spiRxRdy = 1; rxWord = 8'($urandom);
      tick();
    end
    spiTxLoad = 1; tick();
    reset = 1;
    #2;
    checks++;
    if (txLevel !== 5'd0 || rxLevel !== 5'd0 || rxEmpty !== 1'b1 || txData !== FILL) begin
      failures++;
      $display("FAIL midreset_fifo txLevel=%0d rxLevel=%0d empty=%b txData=%h exp 0/0/1/%h", txLevel, rxLevel, rxEmpty, txData, FILL);
    end
    checks++;
    if (txUnderrun !== 1'b0 || rxOverrun !== 1'b0 || frameWords !== 16'd0 || frameDone !== 1'b0) begin
      failures++;
      $display("FAIL midreset_status und=%b ovr=%b words=%0d done=%b exp 0", txUnderrun, rxOverrun, frameWords, frameDone);
    end
    @(posedge clk);
    #1;
    reset = 0;
    modelClear();
    spiEnd = 1; tick();
    checks++;
    if (frameDone !== 1'b1 || txData !== FILL || txLevel !== 5'd0) begin
      failures++;
      $display("FAIL postreset done=%b txData=%h level=%0d exp 1/%h/0", frameDone, txData, txLevel, FILL);
    end
  endtask

  task automatic test_random();
    int rdPct;
    for (int c = 0; c < 3000; c++) begin
      rdPct = (c < 1500) ? 20 : 55;
      spiBusy = 1'($urandom);
      txWrEn = ($urandom_range(0, 99) < 40);
      txWrData = 8'($urandom);
      spiTxLoad = ($urandom_range(0, 99) < 25);
      spiStart = ($urandom_range(0, 99) < 3);
      if (spiStart) spiTxLoad = 1;
      spiEnd = ($urandom_range(0, 99) < 3);
      spiRxRdy = ($urandom_range(0, 99) < 35);
      rxWord = 8'($urandom);
      rxRdEn = ($urandom_range(0, 99) < rdPct);
      clrFlags = ($urandom_range(0, 99) < 5);
      tick();
      checks++;
      if (txData !== mTxData || txLevel !== 5'(txQ.size()) || txFull !== (txQ.size() == 16)) begin
        failures++;
        $display("FAIL rnd_tx cyc=%0d txData=%h lvl=%0d full=%b exp %h/%0d/%b", c, txData, txLevel, txFull, mTxData, txQ.size(), txQ.size() == 16);
      end
      checks++;
      if (rxLevel !== 5'(rxQ.size()) || rxEmpty !== (rxQ.size() == 0) || (rxQ.size() > 0 && rxRdData !== rxQ[0])) begin
        failures++;
        $display("FAIL rnd_rx cyc=%0d lvl=%0d empty=%b head=%h exp lvl %0d", c, rxLevel, rxEmpty, rxRdData, rxQ.size());
      end
      checks++;
      if (txUnderrun !== mUnder || rxOverrun !== mOver) begin
        failures++;
        $display("FAIL rnd_flags cyc=%0d und=%b ovr=%b exp %b/%b", c, txUnderrun, rxOverrun, mUnder, mOver);
      end
      checks++;
      if (frameDone !== mDone || frameWords !== 16'(mWords)) begin
        failures++;
        $display("FAIL rnd_frame cyc=%0d done=%b words=%0d exp %b/%0d", c, frameDone, frameWords, mDone, mWords);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_preload();
    test_tx_full();
    test_rx_overrun();
    test_frame();
    test_full_rx_rdwr();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
